// File: rtl/fifo_uart_tx_pkg.sv
// Definitions shared by the UART transmitter and the matching receiver.
// Holds the frame state encoding and the oversampling ratio.
package fifo_uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int OS_TICKS = 16;

endpackage

// File: rtl/fifo_uart_tx.sv
// UART transmitter on the read side of a FIFO: pops a word whenever idle and
// non-empty, then shifts out start bit, DBIT data bits LSB first, stop period.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            fifo_empty,
   input  logic [DBIT-1:0] fifo_rdata,
   output logic            fifo_rd,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int TICK_MAX = (SB_TICK > OS_TICKS) ? SB_TICK : OS_TICKS;
   localparam int TW       = $clog2(TICK_MAX);
   localparam int BW       = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICKS - 1);
   localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

   uart_state_t     state, state_next;
   logic [TW-1:0]   tick_cnt, tick_cnt_next;
   logic [BW-1:0]   bit_cnt, bit_cnt_next;
   logic [DBIT-1:0] shift_reg, shift_next;
   logic            tx_next;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
      end else begin
         state     <= state_next;
         tick_cnt  <= tick_cnt_next;
         bit_cnt   <= bit_cnt_next;
         shift_reg <= shift_next;
         tx        <= tx_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next    = state;
      tick_cnt_next = tick_cnt;
      bit_cnt_next  = bit_cnt;
      shift_next    = shift_reg;
      fifo_rd       = 1'b0;
      tx_done_tick  = 1'b0;

      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd       = 1'b1;
               shift_next    = fifo_rdata;
               tick_cnt_next = '0;
               state_next    = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (tick_cnt == OS_LAST) begin
                  tick_cnt_next = '0;
                  bit_cnt_next  = '0;
                  state_next    = DATA;
               end else begin
                  tick_cnt_next = tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (tick_cnt == OS_LAST) begin
                  tick_cnt_next = '0;
                  shift_next    = shift_reg >> 1;
                  if (bit_cnt == BIT_LAST) state_next = STOP;
                  else                     bit_cnt_next = bit_cnt + 1'b1;
               end else begin
                  tick_cnt_next = tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (tick_cnt == SB_LAST) begin
                  tx_done_tick = 1'b1;
                  state_next   = IDLE;
               end else begin
                  tick_cnt_next = tick_cnt + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // tx is registered from the next state, so the line moves on the same edge as the FSM.
      unique case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   assign tx_busy = (state != IDLE);

   a_rd_empty: assert property (@(posedge clk) disable iff (reset) !(fifo_rd && fifo_empty))
      else $error("fifo_rd asserted while fifo_empty");
   a_rd_idle: assert property (@(posedge clk) disable iff (reset) !(fifo_rd && state != IDLE))
      else $error("fifo_rd asserted outside IDLE");
   a_done_stop: assert property (@(posedge clk) disable iff (reset) !(tx_done_tick && state != STOP))
      else $error("tx_done_tick outside STOP");
   a_idle_high: assert property (@(posedge clk) disable iff (reset) !(state == IDLE && !tx))
      else $error("tx low in IDLE");

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the FIFO (the end that drives rd/empty).
- Pops one word whenever the FIFO is non-empty and the serializer is idle, then shifts it out as an asynchronous serial frame: start bit, DBIT data bits LSB first, stop period.
- Bit timing comes from an external 16x oversampling tick.
- Sits between the FIFO (controller plus combinational-read register file) and the tx pin.

Parameters:
- DBIT, 8, data bits per frame (5..8 supported).
- SB_TICK, 16, stop-period length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_tick  in  1  one-clk pulse at 16x baud rate.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DBIT  FIFO word at current read pointer; valid combinationally while fifo_empty=0.
- fifo_rd  out  1  pop strobe to FIFO rd input; one clk wide.
- tx  out  1  serial line, idle high; registered.
- tx_busy  out  1  high while any frame is in progress (states START/DATA/STOP).
- tx_done_tick  out  1  one-clk pulse at end of stop period.

Behaviour:
- Reset: state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, tick counter=0, bit counter=0, shift reg=0. Reset asserted mid-frame aborts the frame immediately; tx returns high asynchronously; the aborted word is not re-popped.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If fifo_empty=0: capture fifo_rdata into the shift reg, drive fifo_rd=1 (combinational from state/empty, exactly this one cycle), clear the tick counter, go to START.
  - s_tick is ignored in IDLE.
  - fifo_rd is never asserted while fifo_empty=1 or outside IDLE.
- START: tx=0. Count s_tick; on the 16th tick (counter==15 and s_tick) clear the counter and go to DATA with bit counter=0.
- DATA:
  - tx=shift_reg[0].
  - On the 16th tick: shift right by 1, clear the tick counter.
  - If bit counter==DBIT-1, go to STOP; else increment the bit counter.
- STOP:
  - tx=1.
  - On tick SB_TICK (counter==SB_TICK-1 and s_tick): pulse tx_done_tick for one clk and go to IDLE.
- Latency:
  - Pop to tx falling edge: 1 clk (tx registered from next-state value).
  - Frame length: exactly 16*(1+DBIT)+SB_TICK s_tick pulses.
- Back-to-back frames: after STOP, IDLE re-pops on the next clk if non-empty. The inter-frame gap is one clk plus alignment to the next s_tick, with no extra bit time.
- s_tick is only counted when high. The counter width is sized for max(16, SB_TICK); the bit counter is $clog2(DBIT) bits.
- A FIFO write during a frame has no effect on the frame. The word is held in the shift reg, so the FIFO slot is freed at pop time.
- Assertions:
  - error if fifo_rd & fifo_empty.
  - error if fifo_rd while state!=IDLE.
  - error if tx_done_tick & (state!=STOP).
  - error if tx==0 in IDLE (after time 0).

Decomposition:
- Shared package: state enum typedef (IDLE, START, DATA, STOP) and constant OS_TICKS=16 (oversampling ratio), reused by the matching receiver.
- No sub-module required. The baud/tick generator stays outside and is instantiated at top level alongside this block and the FIFO.

Test Plan:
- Reset, FIFO empty, s_tick every 4 clk for 1000 clk -> tx stays 1, fifo_rd never asserted, tx_busy=0.
- Load 8'hA5 then release FIFO (DBIT=8, SB_TICK=16) -> fifo_rd one clk, tx sequence start 0, bits 1,0,1,0,0,1,0,1, stop 1.
  - Each bit spans exactly 16 ticks.
  - tx_done_tick pulses once after 160 ticks.
- Preload 3 words 8'h01, 8'h80, 8'hFF -> three frames in order, exactly 3 fifo_rd pulses, each within 1 clk of the preceding tx_done_tick; fifo_empty=1 afterward with tx idle.
- Assert reset during bit 3 of 8'h3C -> tx=1 the same cycle, state IDLE.
  - A subsequent word 8'h55 transmits correctly.
  - 8'h3C is never resent.
- SB_TICK=32, DBIT=7, word 7'h41 -> 7 data bits LSB first, stop held high for 32 ticks, tx_busy high for 16*8+32=160 ticks.
- Write to FIFO on the same clk as tx_done_tick while empty -> pop occurs on the next IDLE cycle, no pop while empty, no assertion fires.
